// File: rtl/sram_like_arbiter_if.sv
// Bundle of the N master sram-like ports plus the single slave port seen by the arbiter.
// Per-channel fields are packed [NUM_CH-1:0][W-1:0], so channel i sits at bits [i*W +: W].
interface sram_like_arbiter_if #(
  parameter int NUM_CH    = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_OUTST = 4
);
  localparam int CW = $clog2(MAX_OUTST + 1);

  logic [NUM_CH-1:0]             ch_req;
  logic [NUM_CH-1:0]             ch_wr;
  logic [NUM_CH-1:0][1:0]        ch_size;
  logic [NUM_CH-1:0][ADDR_W-1:0] ch_addr;
  logic [NUM_CH-1:0][DATA_W-1:0] ch_wdata;
  logic [NUM_CH-1:0]             ch_addr_ok;
  logic [NUM_CH-1:0]             ch_data_ok;
  logic [DATA_W-1:0]             ch_rdata;

  logic                          s_req;
  logic                          s_wr;
  logic [1:0]                    s_size;
  logic [ADDR_W-1:0]             s_addr;
  logic [DATA_W-1:0]             s_wdata;
  logic                          s_addr_ok;
  logic                          s_data_ok;
  logic [DATA_W-1:0]             s_rdata;

  logic [CW-1:0]                 outst_cnt;
  logic                          err_unexp;

  modport arb (
    input  ch_req, ch_wr, ch_size, ch_addr, ch_wdata,
    output ch_addr_ok, ch_data_ok, ch_rdata,
    output s_req, s_wr, s_size, s_addr, s_wdata,
    input  s_addr_ok, s_data_ok, s_rdata,
    output outst_cnt, err_unexp
  );

  modport master (
    output ch_req, ch_wr, ch_size, ch_addr, ch_wdata,
    input  ch_addr_ok, ch_data_ok, ch_rdata
  );

  modport slave (
    input  s_req, s_wr, s_size, s_addr, s_wdata,
    output s_addr_ok, s_data_ok, s_rdata
  );
endinterface

// File: rtl/sram_like_arbiter.sv
// Round-robin N:1 sram-like arbiter with in-order response routing via an ID FIFO.
// A stalled grant is locked until accepted; full FIFO blocks new requests (no bypass).

module sram_like_arbiter_ch #(
  parameter int PW     = 1,
  parameter int CH_IDX = 0
) (
  input  logic          acc,
  input  logic [PW-1:0] acc_idx,
  input  logic          rsp,
  input  logic [PW-1:0] rsp_idx,
  output logic          addr_ok,
  output logic          data_ok
);
  assign addr_ok = acc && (acc_idx == PW'(CH_IDX));
  assign data_ok = rsp && (rsp_idx == PW'(CH_IDX));
endmodule

module sram_like_arbiter #(
  parameter int NUM_CH    = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_OUTST = 4
) (
  input logic               clk,
  input logic               resetn,
  sram_like_arbiter_if.arb  bus
);
  localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int FW = $clog2(MAX_OUTST);
  localparam int CW = $clog2(MAX_OUTST + 1);

  logic [PW-1:0] rr_ptr;
  logic          lock;
  logic [PW-1:0] lock_idx;
  logic [PW-1:0] gnt_idx;
  logic          gnt_vld;
  logic [PW-1:0] cand;
  logic [FW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] outst_cnt;
  logic [PW-1:0] id_mem [MAX_OUTST];
  logic [PW-1:0] head;
  logic          full, empty, push, pop;

  // Locked grant wins; otherwise scan upward from rr_ptr, wrapping at NUM_CH.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    if (lock) begin
      gnt_vld = 1'b1;
      gnt_idx = lock_idx;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        cand = PW'((int'(rr_ptr) + k) % NUM_CH);
        if (!gnt_vld && bus.ch_req[cand]) begin
          gnt_vld = 1'b1;
          gnt_idx = cand;
        end
      end
    end
  end

  assign full  = (outst_cnt == CW'(MAX_OUTST));
  assign empty = (outst_cnt == '0);
  assign push  = bus.s_req && bus.s_addr_ok;
  assign pop   = bus.s_data_ok && !empty;
  assign head  = id_mem[rd_ptr];

  assign bus.s_req     = gnt_vld && !full;
  assign bus.s_wr      = bus.ch_wr[gnt_idx];
  assign bus.s_size    = bus.ch_size[gnt_idx];
  assign bus.s_addr    = bus.ch_addr[gnt_idx];
  assign bus.s_wdata   = bus.ch_wdata[gnt_idx];
  assign bus.ch_rdata  = bus.s_rdata;
  assign bus.outst_cnt = outst_cnt;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    sram_like_arbiter_ch #(.PW(PW), .CH_IDX(i)) u_ch (
      .acc     (push),
      .acc_idx (gnt_idx),
      .rsp     (pop),
      .rsp_idx (head),
      .addr_ok (bus.ch_addr_ok[i]),
      .data_ok (bus.ch_data_ok[i])
    );
  end

  // ID storage needs no reset: entries are only read while counted as outstanding.
  always_ff @(posedge clk) begin
    if (push) id_mem[wr_ptr] <= gnt_idx;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rr_ptr        <= '0;
      lock          <= 1'b0;
      lock_idx      <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      outst_cnt     <= '0;
      bus.err_unexp <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        lock   <= 1'b0;
        rr_ptr <= (NUM_CH == 1 || gnt_idx == PW'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
      end else if (bus.s_req) begin
        lock     <= 1'b1;
        lock_idx <= gnt_idx;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   outst_cnt <= outst_cnt + 1'b1;
        2'b01:   outst_cnt <= outst_cnt - 1'b1;
        default: outst_cnt <= outst_cnt;
      endcase
      if (bus.s_data_ok && empty) bus.err_unexp <= 1'b1;
    end
  end
endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter (NUM_CH=2, MAX_OUTST=4) with accept/response scoreboards.
module tb_sram_like_arbiter;
  localparam int NUM_CH = 2, ADDR_W = 32, DATA_W = 32, MAX_OUTST = 4;
  localparam logic [31:0] A0 = 32'h1000_0000, A1 = 32'h2000_0000;

  typedef struct {
    logic [NUM_CH-1:0] vec;
    logic [31:0]       val;
  } exp_t;

  logic clk = 1'b0, resetn = 1'b0;
  int   n_cmp = 0, n_err = 0;
  exp_t exp_acc[$], exp_rsp[$];
  exp_t ma, mr;

  sram_like_arbiter_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUTST(MAX_OUTST)) bus ();

  sram_like_arbiter #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUTST(MAX_OUTST)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk(input logic [NUM_CH-1:0] v, input logic [31:0] d);
    exp_t e;
    e.vec = v;
    e.val = d;
    return e;
  endfunction

  // Monitor: every accept/response the DUT presents must match the oldest expectation.
  always @(negedge clk) begin
    if (resetn) begin
      if (bus.ch_addr_ok != '0) begin
        if (exp_acc.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL acc_unexpected: got ch_addr_ok=%b, expected none", bus.ch_addr_ok);
        end else begin
          ma = exp_acc.pop_front();
          chk("acc_ch", 32'(bus.ch_addr_ok), 32'(ma.vec));
          chk("acc_addr", bus.s_addr, ma.val);
        end
      end
      if (bus.ch_data_ok != '0) begin
        if (exp_rsp.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL rsp_unexpected: got ch_data_ok=%b, expected none", bus.ch_data_ok);
        end else begin
          mr = exp_rsp.pop_front();
          chk("rsp_ch", 32'(bus.ch_data_ok), 32'(mr.vec));
          chk("rsp_rdata", bus.ch_rdata, mr.val);
        end
      end
    end
  end

  initial begin
    bus.ch_req = '0; bus.ch_wr = '0; bus.ch_size = '0; bus.ch_wdata = '0;
    bus.ch_addr[0] = 32'h1111_1111; bus.ch_addr[1] = 32'h2222_2222;
    bus.s_addr_ok = 1'b0; bus.s_data_ok = 1'b0; bus.s_rdata = '0;

    // Reset state
    #3;
    chk("rst_s_req", 32'(bus.s_req), 0);
    chk("rst_addr_ok", 32'(bus.ch_addr_ok), 0);
    chk("rst_outst", 32'(bus.outst_cnt), 0);
    chk("rst_err", 32'(bus.err_unexp), 0);
    chk("rst_s_addr_ch0", bus.s_addr, 32'h1111_1111);
    cyc(); resetn = 1'b1;

    // Single read
    cyc(); bus.ch_req = 2'b01; bus.ch_addr[0] = 32'hBFC0_0000; bus.s_addr_ok = 1'b1;
    exp_acc.push_back(mk(2'b01, 32'hBFC0_0000));
    #2 chk("single_s_req", 32'(bus.s_req), 1);
    cyc(); bus.ch_req = '0; bus.s_addr_ok = 1'b0;
    #2 chk("single_outst1", 32'(bus.outst_cnt), 1);
    cyc();
    cyc(); bus.s_data_ok = 1'b1; bus.s_rdata = 32'h3C1D_0001;
    exp_rsp.push_back(mk(2'b01, 32'h3C1D_0001));
    cyc(); bus.s_data_ok = 1'b0;
    #2 chk("single_outst0", 32'(bus.outst_cnt), 0);

    // Fresh reset so round robin starts at ch0
    cyc(); resetn = 1'b0;
    cyc(); resetn = 1'b1;

    // Round robin: both request, slave always ready
    cyc(); bus.ch_addr[0] = A0; bus.ch_addr[1] = A1; bus.ch_req = 2'b11; bus.s_addr_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_acc.push_back((i % 2 == 0) ? mk(2'b01, A0) : mk(2'b10, A1));
      #2 chk("rr_s_req", 32'(bus.s_req), 1);
      cyc();
    end

    // Full FIFO blocks requests, including the cycle that pops
    #2 chk("full_outst", 32'(bus.outst_cnt), 4);
    chk("full_s_req", 32'(bus.s_req), 0);
    cyc(); bus.s_data_ok = 1'b1; bus.s_rdata = 32'hAAAA_0001;
    exp_rsp.push_back(mk(2'b01, 32'hAAAA_0001));
    #2 chk("full_no_bypass", 32'(bus.s_req), 0);
    cyc(); bus.s_data_ok = 1'b0;
    exp_acc.push_back(mk(2'b01, A0));
    #2 chk("full_s_req_again", 32'(bus.s_req), 1);
    chk("full_outst3", 32'(bus.outst_cnt), 3);
    cyc(); bus.ch_req = '0; bus.s_addr_ok = 1'b0;
    #2 chk("full_outst4", 32'(bus.outst_cnt), 4);

    // Drain two of 1,0,1,0
    cyc(); bus.s_data_ok = 1'b1; bus.s_rdata = 32'hBBBB_0002; exp_rsp.push_back(mk(2'b10, 32'hBBBB_0002));
    cyc(); bus.s_rdata = 32'hBBBB_0003; exp_rsp.push_back(mk(2'b01, 32'hBBBB_0003));
    cyc(); bus.s_data_ok = 1'b0;
    #2 chk("pp_outst_before", 32'(bus.outst_cnt), 2);

    // Same-cycle push and pop (FIFO 1,0 -> pops 1, pushes 1)
    cyc(); bus.ch_req = 2'b10; bus.s_addr_ok = 1'b1; bus.s_data_ok = 1'b1; bus.s_rdata = 32'hBBBB_0004;
    exp_rsp.push_back(mk(2'b10, 32'hBBBB_0004));
    exp_acc.push_back(mk(2'b10, A1));
    cyc(); bus.ch_req = '0; bus.s_addr_ok = 1'b0; bus.s_data_ok = 1'b0;
    #2 chk("pp_outst_after", 32'(bus.outst_cnt), 2);
    cyc(); bus.s_data_ok = 1'b1; bus.s_rdata = 32'hBBBB_0005; exp_rsp.push_back(mk(2'b01, 32'hBBBB_0005));
    cyc(); bus.s_rdata = 32'hBBBB_0006; exp_rsp.push_back(mk(2'b10, 32'hBBBB_0006));
    cyc(); bus.s_data_ok = 1'b0;
    #2 chk("pp_outst_drained", 32'(bus.outst_cnt), 0);

    // Lock: ch1 stalled, ch0 arrives with higher round-robin priority
    cyc(); bus.ch_req = 2'b10; bus.s_addr_ok = 1'b0;
    #2 chk("lock_c1_addr", bus.s_addr, A1);
    chk("lock_c1_req", 32'(bus.s_req), 1);
    cyc(); bus.ch_req = 2'b11;
    #2 chk("lock_c2_addr", bus.s_addr, A1);
    cyc();
    #2 chk("lock_c3_addr", bus.s_addr, A1);
    cyc(); bus.s_addr_ok = 1'b1; exp_acc.push_back(mk(2'b10, A1));
    cyc(); bus.ch_req = 2'b01; exp_acc.push_back(mk(2'b01, A0));
    cyc(); bus.ch_req = '0; bus.s_addr_ok = 1'b0;
    #2 chk("lock_outst", 32'(bus.outst_cnt), 2);
    cyc(); bus.s_data_ok = 1'b1; bus.s_rdata = 32'hCCCC_0001; exp_rsp.push_back(mk(2'b10, 32'hCCCC_0001));
    cyc(); bus.s_rdata = 32'hCCCC_0002; exp_rsp.push_back(mk(2'b01, 32'hCCCC_0002));
    cyc(); bus.s_data_ok = 1'b0;
    #2 chk("lock_outst0", 32'(bus.outst_cnt), 0);

    // Unexpected response with empty FIFO
    cyc(); bus.s_data_ok = 1'b1; bus.s_rdata = 32'hDEAD_BEEF;
    #2 chk("unexp_data_ok", 32'(bus.ch_data_ok), 0);
    chk("unexp_err_before", 32'(bus.err_unexp), 0);
    cyc(); bus.s_data_ok = 1'b0;
    #2 chk("unexp_err_set", 32'(bus.err_unexp), 1);
    chk("unexp_outst", 32'(bus.outst_cnt), 0);
    cyc(); cyc();
    #2 chk("unexp_err_sticky", 32'(bus.err_unexp), 1);
    resetn = 1'b0;
    #1 chk("unexp_err_reset", 32'(bus.err_unexp), 0);

    chk("acc_queue_empty", 32'(exp_acc.size()), 0);
    chk("rsp_queue_empty", 32'(exp_rsp.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
